// File: rtl/ofm_packer.sv
// rtl/ofm_packer.sv - requantize summed MAC results to 8 bits, pack 4 per word, write to OFM memory
// A 2-deep fall-through FIFO sits between the packer and the memory write port.
module ofm_packer #(
    parameter int SUM_W  = 15,
    parameter int SHIFT  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SUM_W-1:0]  in_data,
    input  logic              in_last,
    output logic              ofm_we,
    output logic [ADDR_W-1:0] ofm_addr,
    output logic [31:0]       ofm_wdata,
    input  logic              ofm_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       word_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [15:0]       word_count_q;
    logic [31:0]       pack_q;
    logic [1:0]        idx_q;
    logic [31:0]       fifo_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        cnt_q, cnt_d;

    logic [SUM_W-1:0]  shifted;
    logic [7:0]        byte_val;
    logic [31:0]       word_d;
    logic              xfer, push, pop;

    assign shifted  = in_data >> SHIFT;
    assign byte_val = (shifted > SUM_W'(255)) ? 8'hFF : shifted[7:0];
    assign word_d   = pack_q | ({24'd0, byte_val} << {idx_q, 3'b000});

    // With the FIFO full, bytes that do not complete a word still land in the pack register.
    assign in_ready = (state_q == S_RUN) &&
                      ((cnt_q < 2'd2) || ((idx_q != 2'd3) && !(in_valid && in_last)));
    assign xfer     = in_valid && in_ready;
    assign push     = xfer && ((idx_q == 2'd3) || in_last);
    assign ofm_we   = (cnt_q != 2'd0);
    assign pop      = ofm_we && ofm_ready;

    assign ofm_wdata  = fifo_q[rd_ptr_q];
    assign ofm_addr   = base_q + ADDR_W'(word_count_q);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign word_count = word_count_q;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    // DRAIN looks at the next FIFO count so done follows the final write by one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (xfer && in_last) state_d = S_DRAIN;
            S_DRAIN: if (cnt_d == 2'd0) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            word_count_q <= '0;
            pack_q       <= '0;
            idx_q        <= '0;
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if ((state_q == S_IDLE) && start) begin
                base_q       <= base_addr;
                word_count_q <= '0;
                pack_q       <= '0;
                idx_q        <= '0;
            end
            if (xfer) begin
                if (push) begin
                    pack_q <= '0;
                    idx_q  <= '0;
                end else begin
                    pack_q <= word_d;
                    idx_q  <= idx_q + 2'd1;
                end
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= word_d;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q     <= ~rd_ptr_q;
                word_count_q <= word_count_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ofm_packer.sv
// tb/tb_ofm_packer.sv - directed self-checking bench for ofm_packer
module tb_ofm_packer;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, in_last, ofm_ready;
    logic [31:0] base_addr;
    logic [14:0] in_data;
    logic        in_ready, ofm_we, busy, done;
    logic [31:0] ofm_addr, ofm_wdata;
    logic [15:0] word_count;

    int nvec = 0;
    int nerr = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int cyc = 0, last_wr_cyc = 0, done_cyc = 0, done_hits = 0, acc = 0;

    always #5 clk = ~clk;

    ofm_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .ofm_we     (ofm_we),
        .ofm_addr   (ofm_addr),
        .ofm_wdata  (ofm_wdata),
        .ofm_ready  (ofm_ready),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    always @(negedge clk) begin
        cyc++;
        if (ofm_we && ofm_ready) begin
            wa_q.push_back(ofm_addr);
            wd_q.push_back(ofm_wdata);
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_hits++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [14:0] d, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        check("send_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic begin_tile(input logic [31:0] b);
        wa_q.delete();
        wd_q.delete();
        done_hits = 0;
        start     = 1'b1;
        base_addr = b;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        #1;
        check({tag, "_done_seen"}, done, 1'b1);
        check({tag, "_done_lat"}, done_cyc - last_wr_cyc, 1);
        repeat (3) tick();
        check({tag, "_done_once"}, done_hits, 1);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic exp_wr(input string tag, input int i, input logic [31:0] a, input logic [31:0] d);
        check($sformatf("%s_addr%0d", tag, i), (i < wa_q.size()) ? wa_q[i] : 32'hDEADBEEF, a);
        check($sformatf("%s_data%0d", tag, i), (i < wd_q.size()) ? wd_q[i] : 32'hDEADBEEF, d);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_data = '0; in_last = 1'b0; ofm_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_ofm_we", ofm_we, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_addr", ofm_addr, 32'h0);
        check("rst_wdata", ofm_wdata, 32'h0);
        check("rst_wc", word_count, 16'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // T1: basic packing, two words
        begin_tile(32'h100);
        check("t1_busy", busy, 1'b1);
        for (int i = 1; i <= 8; i++) send(15'(16 * i), i == 8);
        wait_done("t1");
        check("t1_nwr", wa_q.size(), 2);
        exp_wr("t1", 0, 32'h100, 32'h04030201);
        exp_wr("t1", 1, 32'h101, 32'h08070605);
        check("t1_wc", word_count, 16'd2);

        // T2: saturation and truncation boundaries, in_last on byte 3
        begin_tile(32'h200);
        send(15'h7FFF, 1'b0);
        send(15'h0FF0, 1'b0);
        send(15'h000F, 1'b0);
        send(15'h1000, 1'b1);
        wait_done("t2");
        check("t2_nwr", wa_q.size(), 1);
        exp_wr("t2", 0, 32'h200, 32'hFF00FFFF);
        check("t2_wc", word_count, 16'd1);

        // T3: partial final word padded with zeros
        begin_tile(32'h300);
        for (int i = 1; i <= 5; i++) send(15'h10, i == 5);
        wait_done("t3");
        check("t3_nwr", wa_q.size(), 2);
        exp_wr("t3", 0, 32'h300, 32'h01010101);
        exp_wr("t3", 1, 32'h301, 32'h00000001);
        check("t3_wc", word_count, 16'd2);

        // T4: memory stall fills 2 words plus 3 pending bytes
        ofm_ready = 1'b0;
        begin_tile(32'h400);
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_data  = 15'(16 * (acc + 1));
            in_last  = (acc == 11);
            @(negedge clk);
            if (in_ready) acc++;
            if (c == 12) begin
                check("t4_stall_addr_mid", ofm_addr, 32'h400);
                check("t4_stall_data_mid", ofm_wdata, 32'h04030201);
            end
            tick();
        end
        check("t4_accepted", acc, 11);
        @(negedge clk);
        check("t4_in_ready_low", in_ready, 1'b0);
        check("t4_we_held", ofm_we, 1'b1);
        check("t4_stall_addr", ofm_addr, 32'h400);
        check("t4_stall_data", ofm_wdata, 32'h04030201);
        check("t4_no_writes", wa_q.size(), 0);
        tick();
        ofm_ready = 1'b1;
        for (int g = 0; g < 50 && acc < 12; g++) begin
            in_valid = 1'b1;
            in_data  = 15'(16 * (acc + 1));
            in_last  = (acc == 11);
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("t4_accepted_all", acc, 12);
        wait_done("t4");
        check("t4_nwr", wa_q.size(), 3);
        exp_wr("t4", 0, 32'h400, 32'h04030201);
        exp_wr("t4", 1, 32'h401, 32'h08070605);
        exp_wr("t4", 2, 32'h402, 32'h0C0B0A09);
        check("t4_wc", word_count, 16'd3);

        // T5: reset mid-tile discards the queued word
        ofm_ready = 1'b0;
        begin_tile(32'h500);
        for (int i = 0; i < 4; i++) send(15'h10, 1'b0);
        check("t5_queued", ofm_we, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_we", ofm_we, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_wc", word_count, 16'd0);
        tick();
        ofm_ready = 1'b1;
        repeat (5) tick();
        check("t5_no_writes", wa_q.size(), 0);
        begin_tile(32'h600);
        send(15'h20, 1'b0);
        send(15'h30, 1'b0);
        send(15'h40, 1'b0);
        send(15'h50, 1'b1);
        wait_done("t5b");
        check("t5b_nwr", wa_q.size(), 1);
        exp_wr("t5b", 0, 32'h600, 32'h05040302);
        check("t5b_wc", word_count, 16'd1);

        // T6: start and base_addr changes while running are ignored
        begin_tile(32'h700);
        start     = 1'b1;
        base_addr = 32'h7F0;
        send(15'h10, 1'b0);
        send(15'h20, 1'b0);
        send(15'h30, 1'b0);
        send(15'h40, 1'b1);
        start = 1'b0;
        wait_done("t6");
        check("t6_nwr", wa_q.size(), 1);
        exp_wr("t6", 0, 32'h700, 32'h04030201);
        begin_tile(32'h800);
        send(15'h0FF0, 1'b1);
        wait_done("t6b");
        check("t6b_nwr", wa_q.size(), 1);
        exp_wr("t6b", 0, 32'h800, 32'h000000FF);
        check("t6b_wc", word_count, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
